i2c_slave_mb: RTL and testbench
===============================

Name: i2c_slave_mb

Overview:
Parametrised I2C target (slave) that bridges an I2C bus to a simple on-chip register bus. Generalises the single-byte sub-address slave:
- configurable sub-address width and glitch-filter depth
- repeated-START support with the address pointer preserved
- optional auto-increment
- master-NAK handling on reads
- a read-request strobe with a fixed one-cycle read latency

It sits between the chip pads (open-drain SDA/SCL) and the application register file.

Parameters:
SLAVE_ADDR, 7'h70, 7-bit device address matched against the first byte after START.
SUBADDR_BYTES, 1, number of sub-address bytes (legal values 1 or 2). AW = 8*SUBADDR_BYTES.
FILTER_LEN, 3, number of consecutive identical synchronised samples required to accept a level change on SCL or SDA (legal range 2..6).
AUTO_INC, 1, 1 = increment addr after every data byte; 0 = addr stays fixed.

Ports:
clk  input  1  system clock; the only clock
rst  input  1  synchronous, active-high reset
scl_i  input  1  SCL pad input, asynchronous to clk
sda_i  input  1  SDA pad input, asynchronous to clk
sda_o  output  1  constant 0 (open-drain data value)
sda_oe  output  1  1 = pull SDA low
busy  output  1  high from own-address ACK until STOP or abort
rw  output  1  1 = current transaction is a read
addr  output  AW  application address pointer
wen  output  1  one-cycle write strobe
wdata  output  8  write data, valid while wen = 1
ren  output  1  one-cycle read-request strobe
rdata  input  8  read data; must be valid on the cycle after ren

Behaviour:
- Reset (rst = 1 at a clk edge): sda_oe=0, busy=0, rw=0, addr=0, wen=0, wdata=0, ren=0, FSM=IDLE, filters loaded with 1.
- Reset mid-transaction: SDA is released on the next clk edge. There is no bus recovery; the block waits in IDLE for the next START.
- Input conditioning:
  - Each of scl_i and sda_i passes through a 2-flop synchroniser, then a filter.
  - The filtered level toggles only after FILTER_LEN equal samples.
  - Edge flags scl_rise, scl_fall, sda_rise and sda_fall are one-cycle pulses.
  - Pulses shorter than FILTER_LEN clk cycles are ignored.
- Bus conditions:
  - START = sda_fall while filtered SCL = 1.
  - STOP = sda_rise while filtered SCL = 1.
  - Both are detected in any state.
  - START has priority over state logic: it clears the bit counter and moves the FSM to DEV_ADDR.
  - STOP moves the FSM to IDLE.
  - Both release sda_oe on the same edge.
  - addr is never changed by START or STOP.
- Bit timing:
  - Incoming bits are sampled on scl_rise, MSB first.
  - sda_oe changes only on the cycle of a scl_fall, so SDA is stable throughout SCL high.
  - A 3-bit counter counts 8 bits, then the ACK slot follows.
- FSM states and transitions:
  - IDLE: sda_oe=0, busy=0. Exits only on START.
  - DEV_ADDR: shift in 8 bits.
    - If byte[7:1] == SLAVE_ADDR: go to DEV_ACK and latch rw = byte[0].
    - Otherwise: go to IDLE without ACK.
  - DEV_ACK:
    - Drive sda_oe=1 from the scl_fall ending bit 8 until the next scl_fall.
    - busy=1.
    - On that release edge: rw=0 goes to SUB_ADDR (byte index 0); rw=1 goes to RD_FETCH.
  - SUB_ADDR / SUB_ACK:
    - Receive SUBADDR_BYTES bytes, MSB byte first; ACK each one.
    - The full pointer loads into addr on the scl_fall ending the last ACK, then the FSM goes to WR_DATA.
    - If SUBADDR_BYTES=2 and STOP/START arrives after only one byte, addr is unchanged.
  - WR_DATA / WR_ACK:
    - After 8 bits: wdata = byte and wen = 1 for exactly one cycle, in the cycle after the 8th scl_rise, with addr still holding the target address.
    - The ACK is driven.
    - When AUTO_INC=1, addr increments by 1 in the cycle after wen.
    - Loops back to WR_DATA.
  - RD_FETCH:
    - ren = 1 for one cycle using the current addr.
    - On the next cycle, rdata is captured into the shift register.
    - If AUTO_INC=1, addr increments in the same cycle as the capture.
    - Then RD_DATA.
    - RD_FETCH completes within 2 clk cycles of entry, well inside SCL low (no clock stretching).
  - RD_DATA:
    - sda_oe = ~shift[7].
    - Shift left on each scl_fall.
    - After 8 bits, release sda_oe and go to RD_ACK.
  - RD_ACK:
    - Sample SDA on scl_rise: 0 (ACK) goes to RD_FETCH on the following scl_fall.
    - 1 (NAK) goes to IDLE with sda_oe=0; no further ren is issued.
- Arithmetic: addr increments modulo 2^AW (0xFF→0x00, 0xFFFF→0x0000).
- Write followed by repeated START and a read: the read starts at the post-increment pointer.
- wen and ren are never asserted in the same cycle.
- busy falls on the STOP edge or on the transition into IDLE.

Test Plan:
- Write: START, 0xE0, sub 0x10, data 0xA5, 0x3C, STOP -> 4 ACKs; wen at addr=0x10 wdata=0xA5, then addr=0x11 wdata=0x3C; final addr=0x12; busy falls at STOP.
- Address mismatch: START, 0xE2, 0x55, STOP -> sda_oe stays 0 throughout; no wen/ren; busy stays 0.
- Repeated-START read: START, 0xE0, sub 0x20, Sr, 0xE1, read 3 bytes (ACK, ACK, NAK), rdata = addr^0xFF -> ren at 0x20/0x21/0x22; SDA bytes 0xDF, 0xDE, 0xDD; no 4th ren; IDLE after NAK.
- SUBADDR_BYTES=2: sub 0xFF,0xFF, data 0x11, 0x22 -> wen at 0xFFFF then 0x0000; AUTO_INC=0 variant -> both writes at 0xFFFF.
- Filter, FILTER_LEN=3: 2-clk low glitch on SCL during a data bit -> no bit shifted, same byte received; 2-clk SDA glitch while SCL high -> no START/STOP.
- Reset mid-read: assert rst while sda_oe=1 -> sda_oe=0 and addr=0 on the next clk edge; a subsequent full write succeeds.

Source files
------------

// File: rtl/i2c_slave_mb_if.sv
// Signal bundle between the I2C target and the pads / application register file.
interface i2c_slave_mb_if #(
    parameter int AW = 8
);
    logic          scl_i;
    logic          sda_i;
    logic          sda_o;
    logic          sda_oe;
    logic          busy;
    logic          rw;
    logic [AW-1:0] addr;
    logic          wen;
    logic [7:0]    wdata;
    logic          ren;
    logic [7:0]    rdata;
    logic [3:0]    state_dbg;

    // Handshake: wen and ren are single-cycle strobes with no back-pressure. wdata/addr are
    // valid while wen=1; rdata must be valid on the cycle after ren and is consumed at its end.
    modport slave (
        input  scl_i, sda_i, rdata,
        output sda_o, sda_oe, busy, rw, addr, wen, wdata, ren, state_dbg
    );
    modport master (
        output scl_i, sda_i, rdata,
        input  sda_o, sda_oe, busy, rw, addr, wen, wdata, ren, state_dbg
    );
endinterface

// File: rtl/i2c_slave_mb.sv
// I2C target bridging the bus to a simple register interface: multi-byte sub-address,
// repeated START, optional pointer auto-increment, one-cycle read latency.
module i2c_slave_mb #(
    parameter logic [6:0] SLAVE_ADDR    = 7'h70,
    parameter int         SUBADDR_BYTES = 1,
    parameter int         FILTER_LEN    = 3,
    parameter int         AUTO_INC      = 1
) (
    input logic           clk,
    input logic           rst,
    i2c_slave_mb_if.slave bus
);
    localparam int AW = 8 * SUBADDR_BYTES;

    typedef enum logic [3:0] {
        IDLE, DEV_ADDR, DEV_ACK, SUB_ADDR, SUB_ACK, WR_DATA, WR_ACK,
        RD_FETCH, RD_CAP, RD_DATA, RD_ACK
    } state_e;

    // Index 0 = SCL, index 1 = SDA throughout the conditioning path.
    logic [1:0] sync1_q, sync2_q, filt_q, filt_prev_q;
    logic [2:0] cnt_q [2];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q     <= '1;
            sync2_q     <= '1;
            filt_q      <= '1;
            filt_prev_q <= '1;
            cnt_q[0]    <= '0;
            cnt_q[1]    <= '0;
        end else begin
            sync1_q     <= {bus.sda_i, bus.scl_i};
            sync2_q     <= sync1_q;
            filt_prev_q <= filt_q;
            for (int i = 0; i < 2; i++) begin
                if (sync2_q[i] == filt_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == 3'(FILTER_LEN - 1)) begin
                    filt_q[i] <= sync2_q[i];
                    cnt_q[i]  <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + 3'd1;
                end
            end
        end
    end

    logic scl_rise, scl_fall, sda_rise, sda_fall, start_det, stop_det, sda_f;
    assign sda_f     = filt_q[1];
    assign scl_rise  = filt_q[0] & ~filt_prev_q[0];
    assign scl_fall  = ~filt_q[0] & filt_prev_q[0];
    assign sda_rise  = filt_q[1] & ~filt_prev_q[1];
    assign sda_fall  = ~filt_q[1] & filt_prev_q[1];
    assign start_det = sda_fall & filt_q[0];
    assign stop_det  = sda_rise & filt_q[0];

    state_e        state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic          done_q, done_d;
    logic [7:0]    shift_q, shift_d;
    logic [AW-1:0] sub_q, sub_d;
    logic          idx_q, idx_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          rw_q, rw_d, busy_q, busy_d, oe_q, oe_d, wen_q, wen_d;
    logic [7:0]    wdata_q, wdata_d;
    logic [7:0]    rx_byte;

    assign rx_byte = {shift_q[6:0], sda_f};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            done_q    <= 1'b0;
            shift_q   <= '0;
            sub_q     <= '0;
            idx_q     <= 1'b0;
            addr_q    <= '0;
            rw_q      <= 1'b0;
            busy_q    <= 1'b0;
            oe_q      <= 1'b0;
            wen_q     <= 1'b0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            done_q    <= done_d;
            shift_q   <= shift_d;
            sub_q     <= sub_d;
            idx_q     <= idx_d;
            addr_q    <= addr_d;
            rw_q      <= rw_d;
            busy_q    <= busy_d;
            oe_q      <= oe_d;
            wen_q     <= wen_d;
            wdata_q   <= wdata_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        done_d    = done_q;
        shift_d   = shift_q;
        sub_d     = sub_q;
        idx_d     = idx_q;
        addr_d    = addr_q;
        rw_d      = rw_q;
        busy_d    = busy_q;
        oe_d      = oe_q;
        wen_d     = 1'b0;
        wdata_d   = wdata_q;
        if (wen_q && AUTO_INC != 0) addr_d = addr_q + AW'(1);

        if (start_det) begin
            state_d   = DEV_ADDR;
            bit_cnt_d = '0;
            done_d    = 1'b0;
            oe_d      = 1'b0;
        end else if (stop_det) begin
            state_d = IDLE;
            done_d  = 1'b0;
            oe_d    = 1'b0;
        end else begin
            case (state_q)
                IDLE: ;
                // done_q marks "8 bits in, waiting for the SCL fall that opens the ACK slot".
                DEV_ADDR, SUB_ADDR, WR_DATA: begin
                    if (scl_rise && !done_q) begin
                        shift_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            done_d = 1'b1;
                            if (state_q == DEV_ADDR) begin
                                if (rx_byte[7:1] == SLAVE_ADDR) begin
                                    rw_d = rx_byte[0];
                                end else begin
                                    state_d = IDLE;
                                    done_d  = 1'b0;
                                end
                            end else if (state_q == SUB_ADDR) begin
                                sub_d = AW'({sub_q, rx_byte});
                            end else begin
                                wen_d   = 1'b1;
                                wdata_d = rx_byte;
                            end
                        end
                    end else if (scl_fall && done_q) begin
                        done_d = 1'b0;
                        oe_d   = 1'b1;
                        case (state_q)
                            DEV_ADDR: begin
                                state_d = DEV_ACK;
                                busy_d  = 1'b1;
                            end
                            SUB_ADDR: state_d = SUB_ACK;
                            default:  state_d = WR_ACK;
                        endcase
                    end
                end
                DEV_ACK: if (scl_fall) begin
                    oe_d  = 1'b0;
                    idx_d = 1'b0;
                    state_d = rw_q ? RD_FETCH : SUB_ADDR;
                end
                SUB_ACK: if (scl_fall) begin
                    oe_d = 1'b0;
                    if (idx_q == 1'(SUBADDR_BYTES - 1)) begin
                        addr_d  = sub_q;
                        state_d = WR_DATA;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = SUB_ADDR;
                    end
                end
                WR_ACK: if (scl_fall) begin
                    oe_d    = 1'b0;
                    state_d = WR_DATA;
                end
                RD_FETCH: state_d = RD_CAP;
                RD_CAP: begin
                    shift_d   = bus.rdata;
                    oe_d      = ~bus.rdata[7];
                    bit_cnt_d = '0;
                    if (AUTO_INC != 0) addr_d = addr_q + AW'(1);
                    state_d   = RD_DATA;
                end
                RD_DATA: if (scl_fall) begin
                    if (bit_cnt_q == 3'd7) begin
                        oe_d      = 1'b0;
                        bit_cnt_d = '0;
                        done_d    = 1'b0;
                        state_d   = RD_ACK;
                    end else begin
                        shift_d   = {shift_q[6:0], 1'b0};
                        oe_d      = ~shift_q[6];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
                RD_ACK: begin
                    if (scl_rise) begin
                        if (sda_f) state_d = IDLE;
                        else       done_d  = 1'b1;
                    end else if (scl_fall && done_q) begin
                        done_d  = 1'b0;
                        state_d = RD_FETCH;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        if (state_d == IDLE) busy_d = 1'b0;
    end

    assign bus.sda_o     = 1'b0;
    assign bus.sda_oe    = oe_q;
    assign bus.busy      = busy_q;
    assign bus.rw        = rw_q;
    assign bus.addr      = addr_q;
    assign bus.wen       = wen_q;
    assign bus.wdata     = wdata_q;
    assign bus.ren       = (state_q == RD_FETCH);
    assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_i2c_slave_mb.sv
// Bench: three targets on one shared I2C bus (1-byte sub-address, 2-byte auto-inc, 2-byte fixed).
module tb_i2c_slave_mb;
    localparam int EW = 27;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tb_scl = 1'b1;
    logic tb_sda = 1'b1;
    logic sda_line;
    int   checks = 0;
    int   errors = 0;
    logic [EW-1:0] exp_q[$];
    logic oe_seen, busy_seen;

    always #5 clk = ~clk;

    i2c_slave_mb_if #(.AW(8))  b0 ();
    i2c_slave_mb_if #(.AW(16)) b1 ();
    i2c_slave_mb_if #(.AW(16)) b2 ();

    i2c_slave_mb #(.SLAVE_ADDR(7'h70), .SUBADDR_BYTES(1), .FILTER_LEN(3), .AUTO_INC(1))
        dut (.clk(clk), .rst(rst), .bus(b0));
    i2c_slave_mb #(.SLAVE_ADDR(7'h38), .SUBADDR_BYTES(2), .FILTER_LEN(3), .AUTO_INC(1))
        dut1 (.clk(clk), .rst(rst), .bus(b1));
    i2c_slave_mb #(.SLAVE_ADDR(7'h39), .SUBADDR_BYTES(2), .FILTER_LEN(3), .AUTO_INC(0))
        dut2 (.clk(clk), .rst(rst), .bus(b2));

    assign sda_line = tb_sda & ~(b0.sda_oe | b1.sda_oe | b2.sda_oe);
    assign b0.scl_i = tb_scl;
    assign b1.scl_i = tb_scl;
    assign b2.scl_i = tb_scl;
    assign b0.sda_i = sda_line;
    assign b1.sda_i = sda_line;
    assign b2.sda_i = sda_line;

    // Application register file: read data = low address byte inverted, one cycle after ren.
    always @(posedge clk) begin
        if (rst) begin
            b0.rdata <= 8'h00;
            b1.rdata <= 8'h00;
            b2.rdata <= 8'h00;
        end else begin
            if (b0.ren) b0.rdata <= b0.addr ^ 8'hFF;
            if (b1.ren) b1.rdata <= b1.addr[7:0] ^ 8'hFF;
            if (b2.ren) b2.rdata <= b2.addr[7:0] ^ 8'hFF;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    task automatic push(input logic [1:0] dev, input logic wr, input logic [15:0] a, input logic [7:0] d);
        exp_q.push_back({dev, wr, a, d});
    endtask

    // Scoreboard monitor: every strobe pops one expected entry.
    task automatic mon_dev(input logic [1:0] dev, input logic w, input logic r,
                           input logic [15:0] a, input logic [7:0] d);
        logic [EW-1:0] obs, want;
        if (w && r) begin
            checks++;
            errors++;
            $display("FAIL wen_ren_same_cycle: got dev %0d both strobes expected one", dev);
        end
        if (w || r) begin
            obs = {dev, w, a, (w ? d : 8'h00)};
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: got %0h expected none", obs);
            end else begin
                want = exp_q.pop_front();
                check("strobe", 32'(obs), 32'(want));
            end
        end
    endtask

    always @(negedge clk) begin
        mon_dev(2'd0, b0.wen, b0.ren, {8'h00, b0.addr}, b0.wdata);
        mon_dev(2'd1, b1.wen, b1.ren, b1.addr, b1.wdata);
        mon_dev(2'd2, b2.wen, b2.ren, b2.addr, b2.wdata);
        if (b0.sda_oe | b1.sda_oe | b2.sda_oe) oe_seen = 1'b1;
        if (b0.busy | b1.busy | b2.busy) busy_seen = 1'b1;
    end

    // glitch: 0 none, 1 = 2-clk SCL low pulse, 2 = 2-clk SDA pulse, both while SCL is high.
    task automatic bit_cycle(input logic b, input int glitch, output logic smp);
        tb_sda = b;
        tick(5);
        tb_scl = 1'b1;
        tick(5);
        if (glitch == 1) begin
            tb_scl = 1'b0; tick(2); tb_scl = 1'b1;
        end else if (glitch == 2) begin
            tb_sda = ~b; tick(2); tb_sda = b;
        end else begin
            tick(2);
        end
        tick(3);
        smp = sda_line;
        tick(10);
        tb_scl = 1'b0;
        tick(5);
    endtask

    task automatic i2c_start();
        tb_sda = 1'b1; tick(5);
        tb_scl = 1'b1; tick(10);
        tb_sda = 1'b0; tick(10);
        tb_scl = 1'b0; tick(5);
    endtask

    task automatic i2c_stop();
        tb_sda = 1'b0; tick(5);
        tb_scl = 1'b1; tick(10);
        tb_sda = 1'b1; tick(10);
    endtask

    task automatic send_byte(input string name, input logic [7:0] v, input logic want_ack,
                             input int gbit, input int gkind);
        logic [7:0] vv;
        logic smp;
        vv = v;
        for (int i = 0; i < 8; i++) bit_cycle(vv[7-i], (i == gbit) ? gkind : 0, smp);
        bit_cycle(1'b1, 0, smp);
        check(name, {31'b0, ~smp}, {31'b0, want_ack});
    endtask

    task automatic recv_byte(input string name, input logic [7:0] want, input logic m_ack);
        logic [7:0] got;
        logic smp;
        for (int i = 0; i < 8; i++) begin
            bit_cycle(1'b1, 0, smp);
            got = {got[6:0], smp};
        end
        check(name, {24'b0, got}, {24'b0, want});
        bit_cycle(~m_ack, 0, smp);
    endtask

    initial begin
        oe_seen = 1'b0;
        busy_seen = 1'b0;
        rst = 1'b1;
        tick(4);
        rst = 1'b0;
        check("rst_sda_oe", {31'b0, b0.sda_oe}, 0);
        check("rst_sda_o", {31'b0, b0.sda_o}, 0);
        check("rst_busy", {31'b0, b0.busy}, 0);
        check("rst_rw", {31'b0, b0.rw}, 0);
        check("rst_addr", {24'b0, b0.addr}, 0);
        check("rst_wdata", {24'b0, b0.wdata}, 0);
        check("rst_strobes", {30'b0, b0.wen, b0.ren}, 0);
        check("rst_state", {28'b0, b0.state_dbg}, 0);
        tick(10);

        // Single-byte sub-address write with auto-increment.
        i2c_start();
        send_byte("wr_dev_ack", 8'hE0, 1'b1, -1, 0);
        check("wr_busy_high", {31'b0, b0.busy}, 1);
        send_byte("wr_sub_ack", 8'h10, 1'b1, -1, 0);
        push(2'd0, 1'b1, 16'h0010, 8'hA5);
        send_byte("wr_d0_ack", 8'hA5, 1'b1, -1, 0);
        push(2'd0, 1'b1, 16'h0011, 8'h3C);
        send_byte("wr_d1_ack", 8'h3C, 1'b1, -1, 0);
        check("wr_busy_before_stop", {31'b0, b0.busy}, 1);
        i2c_stop();
        check("wr_busy_after_stop", {31'b0, b0.busy}, 0);
        check("wr_final_addr", {24'b0, b0.addr}, 32'h12);

        // Address mismatch: nobody may drive SDA or raise busy.
        oe_seen = 1'b0;
        busy_seen = 1'b0;
        i2c_start();
        send_byte("mm_dev_nak", 8'hE2, 1'b0, -1, 0);
        send_byte("mm_data_nak", 8'h55, 1'b0, -1, 0);
        i2c_stop();
        check("mm_no_sda_oe", {31'b0, oe_seen}, 0);
        check("mm_no_busy", {31'b0, busy_seen}, 0);

        // Sub-address write, repeated START, three-byte read ending in NAK.
        i2c_start();
        send_byte("rd_dev_ack", 8'hE0, 1'b1, -1, 0);
        send_byte("rd_sub_ack", 8'h20, 1'b1, -1, 0);
        i2c_start();
        push(2'd0, 1'b0, 16'h0020, 8'h00);
        push(2'd0, 1'b0, 16'h0021, 8'h00);
        push(2'd0, 1'b0, 16'h0022, 8'h00);
        send_byte("rd_dev2_ack", 8'hE1, 1'b1, -1, 0);
        check("rd_rw", {31'b0, b0.rw}, 1);
        recv_byte("rd_byte0", 8'hDF, 1'b1);
        recv_byte("rd_byte1", 8'hDE, 1'b1);
        recv_byte("rd_byte2", 8'hDD, 1'b0);
        check("rd_idle_after_nak", {28'b0, b0.state_dbg}, 0);
        check("rd_busy_after_nak", {31'b0, b0.busy}, 0);
        i2c_stop();
        check("rd_no_extra_ren", exp_q.size(), 0);
        check("rd_final_addr", {24'b0, b0.addr}, 32'h23);

        // Two-byte sub-address with wrap at 0xFFFF.
        i2c_start();
        send_byte("w2_dev_ack", 8'h70, 1'b1, -1, 0);
        send_byte("w2_sub_hi", 8'hFF, 1'b1, -1, 0);
        send_byte("w2_sub_lo", 8'hFF, 1'b1, -1, 0);
        push(2'd1, 1'b1, 16'hFFFF, 8'h11);
        send_byte("w2_d0", 8'h11, 1'b1, -1, 0);
        push(2'd1, 1'b1, 16'h0000, 8'h22);
        send_byte("w2_d1", 8'h22, 1'b1, -1, 0);
        i2c_stop();
        check("w2_final_addr", {16'b0, b1.addr}, 32'h0001);

        // Only one of two sub-address bytes before STOP leaves the pointer alone.
        i2c_start();
        send_byte("p2_dev_ack", 8'h70, 1'b1, -1, 0);
        send_byte("p2_sub_hi", 8'h12, 1'b1, -1, 0);
        i2c_stop();
        check("p2_addr_kept", {16'b0, b1.addr}, 32'h0001);
        check("p2_busy", {31'b0, b1.busy}, 0);

        // Fixed pointer: both writes land on 0xFFFF.
        i2c_start();
        send_byte("f2_dev_ack", 8'h72, 1'b1, -1, 0);
        send_byte("f2_sub_hi", 8'hFF, 1'b1, -1, 0);
        send_byte("f2_sub_lo", 8'hFF, 1'b1, -1, 0);
        push(2'd2, 1'b1, 16'hFFFF, 8'h11);
        send_byte("f2_d0", 8'h11, 1'b1, -1, 0);
        push(2'd2, 1'b1, 16'hFFFF, 8'h22);
        send_byte("f2_d1", 8'h22, 1'b1, -1, 0);
        i2c_stop();
        check("f2_final_addr", {16'b0, b2.addr}, 32'hFFFF);

        // Short glitches: SDA pulse while SCL high on the sub-address, SCL dropout on data.
        i2c_start();
        send_byte("gl_dev_ack", 8'hE0, 1'b1, -1, 0);
        send_byte("gl_sub_ack", 8'h40, 1'b1, 1, 2);
        push(2'd0, 1'b1, 16'h0040, 8'h5A);
        send_byte("gl_data_ack", 8'h5A, 1'b1, 2, 1);
        i2c_stop();
        check("gl_final_addr", {24'b0, b0.addr}, 32'h41);

        // Reset while the target drives a read bit low.
        i2c_start();
        send_byte("rr_dev_ack", 8'hE0, 1'b1, -1, 0);
        send_byte("rr_sub_ack", 8'h80, 1'b1, -1, 0);
        i2c_start();
        push(2'd0, 1'b0, 16'h0080, 8'h00);
        send_byte("rr_dev2_ack", 8'hE1, 1'b1, -1, 0);
        tick(5);
        check("rr_driving_before_rst", {31'b0, b0.sda_oe}, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rr_sda_released", {31'b0, b0.sda_oe}, 0);
        check("rr_addr_cleared", {24'b0, b0.addr}, 0);
        tick(2);
        rst = 1'b0;
        tb_sda = 1'b1;
        tick(10);
        tb_scl = 1'b1;
        tick(20);
        i2c_start();
        send_byte("rr_w_dev_ack", 8'hE0, 1'b1, -1, 0);
        send_byte("rr_w_sub_ack", 8'h05, 1'b1, -1, 0);
        push(2'd0, 1'b1, 16'h0005, 8'h99);
        send_byte("rr_w_data_ack", 8'h99, 1'b1, -1, 0);
        i2c_stop();
        check("rr_w_final_addr", {24'b0, b0.addr}, 32'h06);

        tick(20);
        check("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
